// File: rtl/fp_round.sv
`default_nettype none
// ============================================================================
//  Module      : fp_round
//  Description : Floating-point rounding stage. Rounds a normalized mantissa
//                (hidden/fraction/guard/round/sticky) to P fraction bits in
//                nearest-even or toward-zero mode. Handles exponent carry,
//                overflow to infinity or max-finite, signed zero and flags.
//                The output register is backed by a one-entry skid buffer.
//                Optional macro FP_ROUND_STICKY_FLAGS_EN enables accumulation
//                of flags_sticky across items accepted downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_round #(
    parameter int P = 23
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    output logic         ready_in,
    input  logic [P+3:0] mant_in,
    input  logic [7:0]   exp_in,
    input  logic         sign_in,
    input  logic         round_mode,
    input  logic [4:0]   flags_in,
    output logic         valid_out,
    input  logic         ready_out,
    output logic [P+8:0] result,
    output logic [4:0]   flags,
    input  logic         flags_clr,
    output logic [4:0]   flags_sticky
);

    localparam int W = P + 9;

    logic         w_inc;
    logic         w_inexact;
    logic         w_carry;
    logic         w_ovf;
    logic [P+4:0] w_sum;
    logic [8:0]   w_exp9;
    logic [P-1:0] w_frac;
    logic [W-1:0] w_res;
    logic [4:0]   w_flags;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic [4:0]   out_flags_q, out_flags_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q,  skid_data_d;
    logic [4:0]   skid_flags_q, skid_flags_d;

    logic         w_accept;
    logic         w_pop;
    logic         w_out_free;

    logic [2:0]   unused_sum_bits;
    assign unused_sum_bits = w_sum[2:0];

    // Rounding datapath: increment decision, carry renormalisation, overflow
    // saturation and zero handling, all combinational on the input item.
    always_comb begin
        w_inexact = |mant_in[2:0];
        w_inc     = !round_mode && mant_in[2] && (mant_in[3] || mant_in[1] || mant_in[0]);
        w_sum     = {1'b0, mant_in} + {{(P+1){1'b0}}, w_inc, 3'b000};
        w_carry   = w_sum[P+4];
        w_frac    = w_carry ? w_sum[P+3:4] : w_sum[P+2:3];
        w_exp9    = {1'b0, exp_in} + {8'd0, w_carry};
        w_ovf     = (w_exp9 >= 9'd255);
        w_res     = {sign_in, w_exp9[7:0], w_frac};
        w_flags   = flags_in | {2'b00, w_ovf, (exp_in == 8'd0) && w_inexact, w_inexact || w_ovf};
        if (w_ovf) begin
            // Nearest-even saturates to infinity, toward-zero to max finite.
            if (round_mode)
                w_res = {sign_in, 8'd254, {P{1'b1}}};
            else
                w_res = {sign_in, 8'd255, {P{1'b0}}};
        end
        if (mant_in == '0) begin
            w_res   = {sign_in, {(W-1){1'b0}}};
            w_flags = flags_in;
        end
    end

    // ready_in is the skid-empty bit, which is itself a register.
    assign ready_in   = !skid_valid_q;
    assign w_accept   = valid_in && ready_in;
    assign w_pop      = out_valid_q && ready_out;
    assign w_out_free = !out_valid_q || ready_out;

    // Output/skid next state: the skid drains into the output first so
    // order is preserved; a new item goes to the skid only when the output
    // is held. An accept while the skid is full cannot happen (ready_in=0).
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_flags_d  = out_flags_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_flags_d = skid_flags_q;
        if (w_out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_flags_d  = skid_flags_q;
                skid_valid_d = 1'b0;
            end else if (w_accept) begin
                out_valid_d  = 1'b1;
                out_data_d   = w_res;
                out_flags_d  = w_flags;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (w_accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = w_res;
            skid_flags_d = w_flags;
        end
    end

    // Pipeline storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_flags_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_flags_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_flags_q  <= out_flags_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_flags_q <= skid_flags_d;
        end
    end

    assign valid_out = out_valid_q;
    assign result    = out_data_q;
    assign flags     = out_flags_q;

`ifdef FP_ROUND_STICKY_FLAGS_EN
    logic [4:0] sticky_q, sticky_d;

    // Clear first, then OR in the item popped this cycle so a same-cycle
    // flag survives the clear.
    always_comb begin
        sticky_d = (flags_clr ? 5'd0 : sticky_q) | (w_pop ? out_flags_q : 5'd0);
    end

    // Sticky flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sticky_q <= '0;
        else
            sticky_q <= sticky_d;
    end

    assign flags_sticky = sticky_q;
`else
    logic unused_sticky_inputs;
    assign unused_sticky_inputs = flags_clr ^ w_pop;
    assign flags_sticky = 5'd0;
`endif

endmodule
`default_nettype wire
